// File: rtl/conv_tree_deserializer_if.sv
// Bundle for the serial input, the relock request and the parallel output of conv_tree_deserializer.
// The master modport is the side that supplies serial data and consumes words; the slave modport is the deserializer.
interface conv_tree_deserializer_if #(
    parameter int INPUTS_NUM = 4
);
    logic                  SERIAL_IN;
    logic                  RELOCK;
    logic [INPUTS_NUM-1:0] PAR_OUT;
    logic                  PAR_VALID;
    logic                  LOCKED;

    modport master (
        output SERIAL_IN,
        output RELOCK,
        input  PAR_OUT,
        input  PAR_VALID,
        input  LOCKED
    );

    modport slave (
        input  SERIAL_IN,
        input  RELOCK,
        output PAR_OUT,
        output PAR_VALID,
        output LOCKED
    );
endinterface

// File: rtl/conv_tree_deserializer.sv
// Rebuilds INPUTS_NUM-bit words from an MSB-first serial stream, aligned on SYNC_WORD while hunting.
// Optional macro CONV_TREE_DESER_OUT_REG_EN adds one output register stage on PAR_OUT/PAR_VALID.
module conv_tree_deserializer #(
    parameter int                    INPUTS_NUM = 4,
    parameter logic [INPUTS_NUM-1:0] SYNC_WORD  = '1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    conv_tree_deserializer_if.slave  bus
);

    localparam int CNT_W = $clog2(INPUTS_NUM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INPUTS_NUM - 1);

    typedef enum logic {
        ST_HUNT,
        ST_LOCKED
    } state_t;

    state_t                  state_q, state_d;
    logic [INPUTS_NUM-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [INPUTS_NUM-1:0]   par_out_q, par_out_d;
    logic                    par_valid_q, par_valid_d;
    logic                    locked_q, locked_d;
    logic [INPUTS_NUM-1:0]   nxt;

    assign nxt = {sr_q[INPUTS_NUM-2:0], bus.SERIAL_IN};

    // RELOCK outranks a sync match on the same edge; sr keeps shifting regardless of state.
    always_comb begin
        sr_d        = nxt;
        state_d     = state_q;
        cnt_d       = cnt_q;
        par_out_d   = par_out_q;
        par_valid_d = 1'b0;
        if (bus.RELOCK) begin
            state_d = ST_HUNT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (nxt == SYNC_WORD) begin
                        state_d = ST_LOCKED;
                        cnt_d   = '0;
                    end
                end
                ST_LOCKED: begin
                    if (cnt_q == CNT_LAST) begin
                        par_out_d   = nxt;
                        par_valid_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    cnt_d   = '0;
                end
            endcase
        end
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_HUNT;
            sr_q        <= '0;
            cnt_q       <= '0;
            par_out_q   <= '0;
            par_valid_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            par_out_q   <= par_out_d;
            par_valid_q <= par_valid_d;
            locked_q    <= locked_d;
        end
    end

`ifdef CONV_TREE_DESER_OUT_REG_EN
    logic [INPUTS_NUM-1:0] par_out_r_q, par_out_r_d;
    logic                  par_valid_r_q, par_valid_r_d;

    // Extra stage ignores RELOCK so a word already captured still reaches the consumer.
    always_comb begin
        par_out_r_d   = par_out_q;
        par_valid_r_d = par_valid_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            par_out_r_q   <= '0;
            par_valid_r_q <= 1'b0;
        end else begin
            par_out_r_q   <= par_out_r_d;
            par_valid_r_q <= par_valid_r_d;
        end
    end

    assign bus.PAR_OUT   = par_out_r_q;
    assign bus.PAR_VALID = par_valid_r_q;
`else
    assign bus.PAR_OUT   = par_out_q;
    assign bus.PAR_VALID = par_valid_q;
`endif

    assign bus.LOCKED = locked_q;

endmodule

// File: tb/tb_conv_tree_deserializer.sv
// Directed bench for conv_tree_deserializer (N=4, SYNC_WORD=4'b1111); PAR_VALID, PAR_OUT and LOCKED are checked every cycle.
// Expected delivery latency follows CONV_TREE_DESER_OUT_REG_EN when the macro is defined for the build.
module tb_conv_tree_deserializer;

`ifdef CONV_TREE_DESER_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   cyc;
    int   pend_cyc[$];
    logic [3:0] pend_word[$];
    logic [3:0] exp_out;
    logic       exp_valid;

    conv_tree_deserializer_if #(.INPUTS_NUM(4)) bus ();

    conv_tree_deserializer #(
        .INPUTS_NUM(4),
        .SYNC_WORD (4'b1111)
    ) dut (
        .CLK  (clk),
        .RESET(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, observed, expected);
        end
    endtask

    // Drive one bit for one edge, then check all outputs just after that edge.
    task automatic applyStimulus(input logic bit_in, input logic relock, input logic exp_lock);
        bus.SERIAL_IN = bit_in;
        bus.RELOCK    = relock;
        @(posedge clk);
        #1;
        cyc++;
        exp_valid = 1'b0;
        if (pend_cyc.size() > 0 && pend_cyc[0] == cyc) begin
            exp_valid = 1'b1;
            exp_out   = pend_word.pop_front();
            void'(pend_cyc.pop_front());
        end
        checkOutput("par_valid", 32'(bus.PAR_VALID), 32'(exp_valid));
        checkOutput("par_out",   32'(bus.PAR_OUT),   32'(exp_out));
        checkOutput("locked",    32'(bus.LOCKED),    32'(exp_lock));
    endtask

    // Payload word while locked; its delivery is expected LAT-1 observations after the LSB edge.
    task automatic sendWord(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) begin
            if (i == 0) begin
                pend_cyc.push_back(cyc + LAT);
                pend_word.push_back(w);
            end
            applyStimulus(w[i], 1'b0, 1'b1);
        end
    endtask

    // Four sync ones from a hunting state whose recent history contains a zero: lock only on the 4th.
    task automatic sendSync();
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
    endtask

    task automatic doReset();
        reset         = 1'b1;
        bus.SERIAL_IN = 1'b0;
        bus.RELOCK    = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        pend_cyc.delete();
        pend_word.delete();
        exp_out = 4'b0000;
        checkOutput("rst_valid",  32'(bus.PAR_VALID), 32'd0);
        checkOutput("rst_out",    32'(bus.PAR_OUT),   32'd0);
        checkOutput("rst_locked", 32'(bus.LOCKED),    32'd0);
        reset = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        cyc           = 0;
        exp_out       = 4'b0000;
        exp_valid     = 1'b0;
        reset         = 1'b1;
        bus.SERIAL_IN = 1'b0;
        bus.RELOCK    = 1'b0;
        @(posedge clk);
        #1;
        doReset();

        $display("[TB] acquire");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        sendSync();
        sendWord(4'b1011);

        $display("[TB] streaming and no false realign");
        sendWord(4'b0101);
        sendWord(4'b1100);
        sendWord(4'b0111);
        sendWord(4'b1111);
        sendWord(4'b0010);

        $display("[TB] relock");
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        // RELOCK held across a complete sync pattern: the match on the 4th one is ignored.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        sendSync();
        sendWord(4'b0110);

        $display("[TB] reset mid-word");
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        doReset();
        sendSync();
        sendWord(4'b1011);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("pending_drained", 32'(pend_cyc.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
